dot_seq: RTL and testbench

Sequencer that feeds one `mac` instance to compute a LEN-term fixed-point dot product for an LSTM gate. On `i_start` it clears the MAC and walks a shared address over the x and weight RAMs (1-cycle read latency). It drives the MAC's `acc` control in step with returning data, then captures the finished sum as `o_y` with a one-cycle `o_valid` pulse. The block sits directly upstream of the MAC, which it controls, and downstream of it, since it consumes `o_mac`.

---
 rtl/lstm_pkg.sv | 15 +
 rtl/dot_seq_if.sv | 33 +++
 rtl/dot_seq_cnt.sv | 23 ++
 rtl/dot_seq.sv | 99 +++++++++
 tb/tb_dot_seq.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/lstm_pkg.sv
// Shared LSTM datapath definitions: sequencer FSM states and default fixed-point format.
package lstm_pkg;

   localparam int unsigned DEF_WIDTH = 32;
   localparam int unsigned DEF_FRAC  = 24;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_RUN,
      S_FLUSH,
      S_LATCH
   } dot_state_t;

endpackage

// File: rtl/dot_seq_if.sv
// Sequencer-side bus between dot_seq, its MAC and the consumer of the result.
// The i_bias member exists only when DOT_SEQ_BIAS_EN is defined.
interface dot_seq_if
   import lstm_pkg::*;
#(
   parameter int unsigned WIDTH  = DEF_WIDTH,
   parameter int unsigned ADDR_W = 3
);
   logic              i_start;
   logic [WIDTH-1:0]  i_mac;
`ifdef DOT_SEQ_BIAS_EN
   logic [WIDTH-1:0]  i_bias;
`endif
   logic [ADDR_W-1:0] o_addr;
   logic              o_acc;
   logic              o_mac_clr;
   logic              o_busy;
   logic [WIDTH-1:0]  o_y;
   logic              o_valid;

`ifdef DOT_SEQ_BIAS_EN
   modport slave  (input  i_start, i_mac, i_bias,
                   output o_addr, o_acc, o_mac_clr, o_busy, o_y, o_valid);
   modport master (output i_start, i_mac, i_bias,
                   input  o_addr, o_acc, o_mac_clr, o_busy, o_y, o_valid);
`else
   modport slave  (input  i_start, i_mac,
                   output o_addr, o_acc, o_mac_clr, o_busy, o_y, o_valid);
   modport master (output i_start, i_mac,
                   input  o_addr, o_acc, o_mac_clr, o_busy, o_y, o_valid);
`endif

endinterface

// File: rtl/dot_seq_cnt.sv
// Shared RAM address counter with clear, enable and terminal-count (== LEN-1) flag.
module dot_seq_cnt #(
   parameter int unsigned LEN    = 8,
   parameter int unsigned ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   output logic [ADDR_W-1:0] cnt,
   output logic              tc
);

   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (en)
         cnt <= cnt + 1'b1;
   end

   assign tc = (cnt == ADDR_W'(LEN - 1));

endmodule

// File: rtl/dot_seq.sv
// LEN-term dot-product sequencer driving one MAC over shared x/weight RAM addresses.
// Optional DOT_SEQ_BIAS_EN adds i_bias to the captured sum.
module dot_seq
   import lstm_pkg::*;
#(
   parameter int unsigned WIDTH  = DEF_WIDTH,
   parameter int unsigned FRAC   = DEF_FRAC,
   parameter int unsigned LEN    = 8,
   parameter int unsigned ADDR_W = 3
) (
   input logic      clk,
   input logic      rst,
   dot_seq_if.slave bus
);

   if (LEN < 1 || LEN > (1 << ADDR_W) || FRAC >= WIDTH) begin : g_param_check
      $error("dot_seq: illegal LEN/ADDR_W/FRAC combination");
   end

   dot_state_t       state, state_nx;
   logic             cnt_clr, cnt_en, cnt_tc;
   logic             acc_q, clr_q, busy_q, valid_q;
   logic [WIDTH-1:0] y_q, y_nx;

   dot_seq_cnt #(
      .LEN    (LEN),
      .ADDR_W (ADDR_W)
   ) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .en  (cnt_en),
      .cnt (bus.o_addr),
      .tc  (cnt_tc)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      cnt_clr  = 1'b0;
      cnt_en   = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.i_start) begin
               state_nx = S_CLR;
               cnt_clr  = 1'b1;
            end
         end
         S_CLR:   state_nx = S_RUN;
         S_RUN: begin
            if (cnt_tc)
               state_nx = S_FLUSH;
            else
               cnt_en = 1'b1;
         end
         S_FLUSH: state_nx = S_LATCH;
         S_LATCH: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

`ifdef DOT_SEQ_BIAS_EN
   assign y_nx = bus.i_mac + bus.i_bias;
`else
   assign y_nx = bus.i_mac;
`endif

   // Control outputs come from next-state so they line up with the state they describe;
   // acc is the RUN state delayed once to match the RAM read latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q   <= 1'b0;
         clr_q   <= 1'b0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         y_q     <= '0;
      end else begin
         acc_q   <= (state == S_RUN);
         clr_q   <= (state_nx == S_CLR);
         busy_q  <= (state_nx != S_IDLE);
         valid_q <= (state == S_LATCH);
         if (state == S_LATCH)
            y_q <= y_nx;
      end
   end

   assign bus.o_acc     = acc_q;
   assign bus.o_mac_clr = clr_q;
   assign bus.o_busy    = busy_q;
   assign bus.o_valid   = valid_q;
   assign bus.o_y       = y_q;

endmodule

// File: tb/tb_dot_seq.sv
// Self-checking bench for dot_seq with behavioural MAC and 1-cycle RAMs; also runs a LEN=1 instance.
module tb_dot_seq;
   import lstm_pkg::*;

   localparam int unsigned WIDTH  = 32;
   localparam int unsigned FRAC   = 24;
   localparam int unsigned LEN    = 8;
   localparam int unsigned ADDR_W = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [WIDTH-1:0] x_mem [0:LEN-1];
   logic [WIDTH-1:0] w_mem [0:LEN-1];
   logic [WIDTH-1:0] bias_v = 32'hFF00_0000;

   dot_seq_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();
   dot_seq_if #(.WIDTH(WIDTH), .ADDR_W(1))      bus1 ();

   dot_seq #(.WIDTH(WIDTH), .FRAC(FRAC), .LEN(LEN), .ADDR_W(ADDR_W)) u_dut (
      .clk (clk), .rst (rst), .bus (bus)
   );
   dot_seq #(.WIDTH(WIDTH), .FRAC(FRAC), .LEN(1), .ADDR_W(1)) u_dut1 (
      .clk (clk), .rst (rst), .bus (bus1)
   );

   function automatic logic [WIDTH-1:0] fx_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      longint p;
      p = longint'($signed(a)) * longint'($signed(b));
      return p[FRAC+WIDTH-1:FRAC];
   endfunction

   // Behavioural MACs (clear on o_mac_clr) fed by 1-cycle-latency RAMs
   logic [WIDTH-1:0] x_q, w_q, mac_q, x1_q, w1_q, mac1_q;
   always @(posedge clk) begin
      x_q  <= x_mem[bus.o_addr];
      w_q  <= w_mem[bus.o_addr];
      x1_q <= x_mem[3'(bus1.o_addr)];
      w1_q <= w_mem[3'(bus1.o_addr)];
      if (bus.o_mac_clr)   mac_q  <= '0;
      else if (bus.o_acc)  mac_q  <= mac_q + fx_mul(x_q, w_q);
      if (bus1.o_mac_clr)  mac1_q <= '0;
      else if (bus1.o_acc) mac1_q <= mac1_q + fx_mul(x1_q, w1_q);
   end
   assign bus.i_mac  = mac_q;
   assign bus1.i_mac = mac1_q;
`ifdef DOT_SEQ_BIAS_EN
   assign bus.i_bias  = bias_v;
   assign bus1.i_bias = bias_v;
`endif

   function automatic logic [WIDTH-1:0] with_bias(input logic [WIDTH-1:0] s);
`ifdef DOT_SEQ_BIAS_EN
      return s + bias_v;
`else
      return s;
`endif
   endfunction

   function automatic logic [WIDTH-1:0] ref_dot(input int unsigned n);
      logic [WIDTH-1:0] s = '0;
      for (int unsigned k = 0; k < n; k++) s += fx_mul(x_mem[k], w_mem[k]);
      return with_bias(s);
   endfunction

   task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic load(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xs, input logic [WIDTH-1:0] wv);
      for (int unsigned k = 0; k < LEN; k++) begin
         x_mem[k] = xa + xs * WIDTH'(k);
         w_mem[k] = wv;
      end
   endtask

   task automatic load_rand();
      for (int unsigned k = 0; k < LEN; k++) begin
         x_mem[k] = $urandom;
         w_mem[k] = $urandom;
      end
   endtask

   // Called at the sampling point of cycle 0 (or of the previous o_valid cycle when pre_started).
   task automatic do_run(input string tag, input logic [WIDTH-1:0] exp,
                         input bit pre_started, input bit chain, input bit poke);
      logic [3:0] ctl_exp;
      if (!pre_started) bus.i_start = 1'b1;
      step();
      bus.i_start = 1'b0;
      for (int unsigned c = 1; c <= LEN + 4; c++) begin
         ctl_exp = {c == 1, c >= 1 && c <= LEN + 3, c >= 3 && c <= LEN + 2, c == LEN + 4};
         check({tag, "/ctl"}, 32'({bus.o_mac_clr, bus.o_busy, bus.o_acc, bus.o_valid}), 32'(ctl_exp));
         if (c <= LEN + 2)
            check({tag, "/addr"}, 32'(bus.o_addr),
                  (c <= 2) ? 32'd0 : (c <= LEN + 1) ? 32'(c - 2) : 32'(LEN - 1));
         if (poke && c == 5) bus.i_start = 1'b1;
         if (poke && c == 6) bus.i_start = 1'b0;
         if (c == LEN + 4) begin
            check({tag, "/y"}, bus.o_y, exp);
            if (chain) bus.i_start = 1'b1;
         end else begin
            step();
         end
      end
   endtask

   task automatic idle_check(input string tag, input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         step();
         check({tag, "/idle"}, 32'({bus.o_busy, bus.o_valid}), 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int unsigned n;
      rst = 1'b1;
      bus.i_start  = 1'b0;
      bus1.i_start = 1'b0;
      load(32'h0100_0000, 32'h0, 32'h0080_0000);
      step(); step();
      check("reset/ctl", 32'({bus.o_addr, bus.o_mac_clr, bus.o_busy, bus.o_acc, bus.o_valid}), 32'd0);
      check("reset/y", bus.o_y, 32'd0);
      rst = 1'b0;
      step();

      // 1.0 * 0.5 over 8 terms
      do_run("half", with_bias(32'h0400_0000), 1'b0, 1'b0, 1'b0);
      idle_check("half", 3);

      // k * 1.0 times -1.0, chained into 0.25 * 0.25
      load(32'h0, 32'h0100_0000, 32'hFF00_0000);
      do_run("ramp", with_bias(32'hE400_0000), 1'b0, 1'b1, 1'b0);
      load(32'h0040_0000, 32'h0, 32'h0040_0000);
      do_run("b2b", with_bias(32'h0080_0000), 1'b1, 1'b0, 1'b0);
      idle_check("b2b", 2);

      // Reset mid-run, then 1.0 * 1.0
      load_rand();
      bus.i_start = 1'b1;
      step();
      bus.i_start = 1'b0;
      for (int unsigned c = 1; c < 5; c++) step();
      rst = 1'b1;
      step();
      check("abort/ctl", 32'({bus.o_addr, bus.o_mac_clr, bus.o_busy, bus.o_acc, bus.o_valid}), 32'd0);
      check("abort/y", bus.o_y, 32'd0);
      rst = 1'b0;
      idle_check("abort", 16);
      load(32'h0100_0000, 32'h0, 32'h0100_0000);
      do_run("restart", with_bias(32'h0800_0000), 1'b0, 1'b0, 1'b0);

      // Start pulsed during RUN is ignored
      load(32'h0100_0000, 32'h0, 32'h0080_0000);
      do_run("poke", with_bias(32'h0400_0000), 1'b0, 1'b0, 1'b1);
      idle_check("poke", 2 * (LEN + 4));

      // Random data against the arithmetic model
      for (int unsigned r = 0; r < 6; r++) begin
         load_rand();
         bias_v = $urandom;
         do_run($sformatf("rand%0d", r), ref_dot(LEN), 1'b0, (r % 2) == 0, 1'b0);
      end
      bus.i_start = 1'b0;
      idle_check("rand", 2 * (LEN + 4));

      // LEN=1 instance: latency 5
      load_rand();
      bus1.i_start = 1'b1;
      step();
      bus1.i_start = 1'b0;
      n = 1;
      while (!bus1.o_valid && n < 20) begin
         step();
         n++;
      end
      check("len1/latency", n, 32'd5);
      check("len1/y", bus1.o_y, ref_dot(1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
